// File: rtl/p251_rej_sampler.sv
// Rejection sampler: scans WIDTH-bit random words byte by byte and emits bytes <= 250 as GF(251) elements.
// Latency: byte 0 is presented one cycle after its word is accepted; one cycle per byte, one LOAD cycle per word.
// Backpressure: a pending element holds (stable o_elem/o_elem_valid) until i_elem_ready; no word is fetched meanwhile.
module p251_rej_sampler #(
    parameter int WIDTH  = 32,
    parameter int N_ELEM = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_word_valid,
    output logic             o_word_ready,
    output logic [7:0]       o_elem,
    output logic             o_elem_valid,
    input  logic             i_elem_ready,
    output logic             o_busy,
    output logic             o_done
);
    localparam int NB    = WIDTH / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   word_buf;
    logic [IDX_W-1:0]   byte_idx;
    logic [15:0]        elem_cnt;
    logic [7:0]         cur_byte;
    logic               in_scan;
    logic               byte_ok;
    logic               last_byte;
    logic               elem_hs;
    logic               byte_adv;
    logic               cnt_last;

    always_comb begin
        cur_byte = '0;
        for (int i = 0; i < NB; i++) begin
            if (byte_idx == IDX_W'(i)) cur_byte = word_buf[8*i +: 8];
        end
    end

    assign in_scan   = (state == S_SCAN);
    assign byte_ok   = (cur_byte <= 8'd250);
    assign last_byte = (byte_idx == IDX_W'(NB - 1));
    assign elem_hs   = in_scan && byte_ok && i_elem_ready;
    // A rejected byte always advances; an accepted one only on its handshake.
    assign byte_adv  = in_scan && (!byte_ok || i_elem_ready);
    assign cnt_last  = ((elem_cnt + 16'd1) == 16'(N_ELEM));

    always_comb begin
        state_nxt    = state;
        o_word_ready = 1'b0;
        o_elem_valid = 1'b0;
        o_elem       = 8'd0;
        o_busy       = (state != S_IDLE);
        o_done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                o_word_ready = 1'b1;
                if (i_word_valid) state_nxt = S_SCAN;
            end
            S_SCAN: begin
                o_elem_valid = byte_ok;
                o_elem       = byte_ok ? cur_byte : 8'd0;
                if (elem_hs && cnt_last) state_nxt = S_DONE;
                else if (byte_adv && last_byte) state_nxt = S_LOAD;
            end
            S_DONE: begin
                o_done    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            word_buf <= '0;
            byte_idx <= '0;
            elem_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && i_start) elem_cnt <= '0;
            if (elem_hs) elem_cnt <= elem_cnt + 16'd1;
            if (state == S_LOAD && i_word_valid) begin
                word_buf <= i_word;
                byte_idx <= '0;
            end else if (byte_adv && !last_byte) begin
                byte_idx <= byte_idx + IDX_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_p251_rej_sampler.sv
// Bench for p251_rej_sampler: directed vector table, hand sequences for stall/reset, randomized runs vs a byte-stream model.
module tb_p251_rej_sampler;
    localparam int W = 32;
    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_start;
    logic [W-1:0] i_word;
    logic         i_word_valid;
    logic         o_word_ready;
    logic [7:0]   o_elem;
    logic         o_elem_valid;
    logic         i_elem_ready;
    logic         o_busy;
    logic         o_done;

    always #5 clk = ~clk;

    p251_rej_sampler #(.WIDTH(W), .N_ELEM(N)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start),
        .i_word(i_word), .i_word_valid(i_word_valid), .o_word_ready(o_word_ready),
        .o_elem(o_elem), .o_elem_valid(o_elem_valid), .i_elem_ready(i_elem_ready),
        .o_busy(o_busy), .o_done(o_done)
    );

    typedef struct packed {
        logic [7:0][31:0]  w;
        logic [N-1:0][7:0] e;
        logic [3:0]        ew;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference: flatten words into a byte stream, keep the first N bytes <= 250.
    function automatic vec_t model(input logic [7:0][31:0] w);
        vec_t       r;
        int         k;
        logic [7:0] by;
        r   = '0;
        r.w = w;
        k   = 0;
        for (int i = 0; i < 8; i++) begin
            for (int b = 0; b < 4; b++) begin
                by = w[i][8*b +: 8];
                if (k < N && by <= 8'd250) begin
                    r.e[k] = by;
                    k++;
                    if (k == N) r.ew = 4'(i + 1);
                end
            end
        end
        return r;
    endfunction

    task automatic run_case(input vec_t v, input bit rnd, input string tag);
        int         wi = 0;
        int         ei = 0;
        bit         last_seen = 0;
        bit         fin = 0;
        bit         prev_stall = 0;
        logic [7:0] prev_elem = 8'd0;
        @(negedge clk);
        i_start = 1'b1; i_word_valid = 1'b0; i_elem_ready = 1'b0;
        @(negedge clk);
        i_start = 1'b0;
        #1;
        check({tag, " busy_after_start"}, o_busy, 1);
        check({tag, " wready_after_start"}, o_word_ready, 1);
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            if (cyc > 0) @(negedge clk);
            i_word       = (wi < 8) ? v.w[wi] : $urandom;
            i_word_valid = rnd ? ($urandom % 3 != 0) : 1'b1;
            i_elem_ready = rnd ? ($urandom % 4 != 0) : 1'b1;
            i_start      = rnd ? ($urandom % 6 == 0) : 1'b0;
            #1;
            if (prev_stall) begin
                check({tag, " stall_valid"}, o_elem_valid, 1);
                check({tag, " stall_data"}, o_elem, prev_elem);
            end
            if (last_seen) begin
                check({tag, " done_pulse"}, o_done, 1);
                check({tag, " words_used"}, wi, v.ew);
                fin = 1;
            end else begin
                check({tag, " no_early_done"}, o_done, 0);
                if (o_word_ready && i_word_valid) wi++;
                if (o_elem_valid) begin
                    check({tag, " elem_range"}, 32'(o_elem <= 8'd250), 1);
                    if (i_elem_ready) begin
                        check($sformatf("%s elem%0d", tag, ei), o_elem, v.e[ei]);
                        ei++;
                        if (ei == N) last_seen = 1;
                    end
                end
            end
            prev_stall = o_elem_valid && !i_elem_ready;
            prev_elem  = o_elem;
        end
        if (!fin) check({tag, " timeout"}, 0, 1);
        @(negedge clk);
        i_start = 1'b0; i_word_valid = 1'b0;
        #1;
        check({tag, " busy_drop"}, o_busy, 0);
        check({tag, " done_once"}, o_done, 0);
    endtask

    vec_t vecs[4];
    vec_t rv;
    logic [7:0][31:0] rw;

    initial begin
        rst_n = 1'b0; i_start = 1'b0; i_word = '0; i_word_valid = 1'b0; i_elem_ready = 1'b0;
        #1;
        check("rst wready", o_word_ready, 0);
        check("rst elem", o_elem, 0);
        check("rst evalid", o_elem_valid, 0);
        check("rst busy", o_busy, 0);
        check("rst done", o_done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) vecs[i] = '0;
        vecs[0].w[0] = 32'h03FCFB00; vecs[0].w[1] = 32'h00000005;
        vecs[0].e[0] = 8'h00; vecs[0].e[1] = 8'h03; vecs[0].e[2] = 8'h05; vecs[0].ew = 4'd2;
        vecs[1].w[0] = 32'hFBFAFFFA; vecs[1].w[1] = 32'h000000FA;
        vecs[1].e[0] = 8'hFA; vecs[1].e[1] = 8'hFA; vecs[1].e[2] = 8'hFA; vecs[1].ew = 4'd2;
        vecs[2].w[0] = 32'hFFFFFFFF; vecs[2].w[1] = 32'hFFFFFFFF;
        vecs[2].w[2] = 32'hFFFFFFFF; vecs[2].w[3] = 32'h00000001;
        vecs[2].e[0] = 8'h01; vecs[2].e[1] = 8'h00; vecs[2].e[2] = 8'h00; vecs[2].ew = 4'd4;
        vecs[3].w[0] = 32'h01020304; vecs[3].w[1] = 32'h0A0B0C0D;
        vecs[3].e[0] = 8'h04; vecs[3].e[1] = 8'h03; vecs[3].e[2] = 8'h02; vecs[3].ew = 4'd1;

        for (int i = 0; i < 4; i++) run_case(vecs[i], 1'b0, $sformatf("vec%0d", i));

        // Backpressure: 0x7B held pending for five cycles.
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0; i_word = 32'h0000007B; i_word_valid = 1'b1; i_elem_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (o_elem_valid) break;
        end
        i_word_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("bp valid", o_elem_valid, 1);
            check("bp elem", o_elem, 8'h7B);
            check("bp wready", o_word_ready, 0);
            @(negedge clk);
            #1;
        end
        i_elem_ready = 1'b1;
        check("bp release elem", o_elem, 8'h7B);
        @(negedge clk); #1;
        check("bp e1", o_elem, 8'h00);
        @(negedge clk); #1;
        check("bp e2", o_elem, 8'h00);
        check("bp e2 valid", o_elem_valid, 1);
        @(negedge clk); #1;
        check("bp done", o_done, 1);
        @(negedge clk); #1;
        check("bp idle", o_busy, 0);
        i_elem_ready = 1'b0;

        // Reset in the middle of SCAN.
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0; i_word = 32'h01010101; i_word_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre_rst valid", o_elem_valid, 1);
        rst_n = 1'b0;
        #1;
        check("midrst wready", o_word_ready, 0);
        check("midrst elem", o_elem, 0);
        check("midrst evalid", o_elem_valid, 0);
        check("midrst busy", o_busy, 0);
        check("midrst done", o_done, 0);
        @(negedge clk);
        check("midrst done2", o_done, 0);
        rst_n = 1'b1; i_word_valid = 1'b0;
        @(negedge clk); #1;
        check("postrst done", o_done, 0);
        check("postrst busy", o_busy, 0);

        // Randomized runs, with spurious i_start pulses mixed in.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 8; i++) begin
                for (int b = 0; b < 4; b++)
                    rw[i][8*b +: 8] = ($urandom % 2 != 0) ? 8'($urandom_range(245, 255)) : 8'($urandom);
            end
            if (t % 4 == 0) rw[0] = 32'hFFFFFFFF;
            rw[7] = 32'h00000000;
            rv = model(rw);
            run_case(rv, 1'b1, $sformatf("rnd%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
